fir_csd_varcoef_filter: RTL and testbench
=========================================

# fir_csd_varcoef_filter

Multiplierless direct-form FIR low-pass/decimation-prep filter for the iCESDM sigma-delta readout chain. It sits downstream of the SDM/CIC stage and consumes one signed sample per enabled clock. The block combines two parts: an ORDER-deep tap delay line, and a shift-and-add (canonical signed digit) coefficient network with a parameterised coefficient set. It produces a registered, scaled, saturated output sample.

## Interface
- I_WIDTH, 16, input sample width (signed two's complement)
- O_WIDTH, 24, output sample width (signed)
- ORDER, 17, number of taps
- C_WIDTH, 10, coefficient width (signed)
- N_SHIFT, 9, arithmetic right shift applied to the accumulator (coefficient scale 2^N_SHIFT)
- COEFS, {2,6,12,20,30,41,51,58,72,58,51,41,30,20,12,6,2}, packed ORDER×C_WIDTH; tap k at bits [k*C_WIDTH +: C_WIDTH]; default sums to 512 (unity DC gain)
- i_clk  input  1  single clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_en  input  1  sample enable; delay line and output advance only when high
- i_data  input  I_WIDTH  signed input sample
- o_taps  output  ORDER*I_WIDTH  delay-line contents; tap k at [k*I_WIDTH +: I_WIDTH], tap 0 newest
- o_data  output  O_WIDTH  signed filtered sample, registered
- o_valid  output  1  high for the cycle after each enabled update

## Operation
- Delay line: on a rising edge with i_en=1, tap0<=i_data and tap k<=tap k-1 for k=1..ORDER-1. Tap ORDER-1 is discarded. With i_en=0, all taps hold.
- Products: each tap×COEFS[k] is formed without the `*` operator. At elaboration, each coefficient is recoded into CSD digits in {-1,0,+1}. Each nonzero digit contributes ±(tap <<< position), with the tap sign-extended first. Zero coefficients generate no logic. Negative coefficients are legal.
- Accumulator: the signed sum of all partial products. Width is I_WIDTH+C_WIDTH+ceil(log2(ORDER)); no intermediate overflow is permitted.
- Scaling: result = acc >>> N_SHIFT (arithmetic, truncation toward −∞).
- Output: the result is saturated to the signed O_WIDTH range (max 2^(O_WIDTH-1)−1, min −2^(O_WIDTH-1)). It is registered into o_data on a rising edge with i_en=1; otherwise o_data holds.
- o_valid <= i_en on every edge.

## Timing
- Reset (async, immediate): all taps=0, o_data=0, o_valid=0.
- Releasing reset requires no extra cycles; the first edge with i_en=1 after release is a normal update.
- Latency, input to tap0: 1 enabled edge.
- Latency, tap change to o_data: 1 further enabled edge. A sample presented before enabled edge n first affects o_data after enabled edge n+1.
- Full step settling: o_data reaches its final value ORDER+1 enabled edges after the step is applied.
- The combinational path from taps to the o_data register must close in one i_clk period.
- Reset mid-stream: taps and output clear at once. Post-reset output builds up from zero history, so no stale samples remain.
- i_en low mid-stream: complete freeze. Re-asserting i_en resumes with no lost or duplicated sample.

## Test plan
- Reset: assert i_rst with taps non-zero → o_taps=0, o_data=0, o_valid=0 immediately, without waiting for a clock edge.
- Impulse: i_en=1, i_data=512 for one sample, then 0. o_data sequence from the second edge: 2,6,12,20,30,41,51,58,72,58,…,2, then 0. This equals COEFS.
- Step: i_data 0 → 1000 held. o_data rises monotonically and equals 1000 from edge ORDER+1 onward.
- Negative step: i_data = −32768 held → o_data settles to −32768, confirming sign extension and arithmetic shift.
- Small input: i_data = 1 held → o_data settles to 1. Intermediate outputs are the floor of the partial sums divided by 512.
- Enable gating: hold i_en=0 for 5 cycles during a step response → o_taps and o_data frozen and o_valid=0. After i_en returns high, the sequence continues where it stopped.

Source files
------------

// File: rtl/fir_csd_varcoef_filter_if.sv
// Sample-side bus of the CSD FIR filter: the producer drives the enable and the
// input sample, and the filter returns its delay line, output sample and valid.
interface fir_csd_varcoef_filter_if #(
  parameter int I_WIDTH = 16,
  parameter int O_WIDTH = 24,
  parameter int ORDER   = 17
);
  logic                       i_en;
  logic signed [I_WIDTH-1:0]  i_data;
  logic [ORDER*I_WIDTH-1:0]   o_taps;
  logic signed [O_WIDTH-1:0]  o_data;
  logic                       o_valid;

  // Producer side (upstream CIC stage or testbench)
  modport master (
    output i_en,
    output i_data,
    input  o_taps,
    input  o_data,
    input  o_valid
  );

  // Filter side
  modport slave (
    input  i_en,
    input  i_data,
    output o_taps,
    output o_data,
    output o_valid
  );
endinterface

// File: rtl/fir_csd_varcoef_filter.sv
// Multiplierless direct-form FIR for the sigma-delta readout chain.
// Each coefficient is recoded into canonical signed digits at elaboration time,
// so every tap product becomes a handful of shifted adds/subtracts of the
// sign-extended tap. The summed accumulator is scaled by an arithmetic right
// shift, saturated to the output width and registered.
module fir_csd_varcoef_filter #(
  parameter int I_WIDTH = 16,
  parameter int O_WIDTH = 24,
  parameter int ORDER   = 17,
  parameter int C_WIDTH = 10,
  parameter int N_SHIFT = 9,
  parameter logic [ORDER*C_WIDTH-1:0] COEFS = {
    10'sd2,  10'sd6,  10'sd12, 10'sd20, 10'sd30, 10'sd41,
    10'sd51, 10'sd58, 10'sd72, 10'sd58, 10'sd51, 10'sd41,
    10'sd30, 10'sd20, 10'sd12, 10'sd6,  10'sd2
  }
) (
  input logic i_clk,
  input logic i_rst,
  fir_csd_varcoef_filter_if.slave bus
);

  // Accumulator wide enough that the sum of all products can never overflow
  localparam int ACC_W = I_WIDTH + C_WIDTH + $clog2(ORDER);
  // A C_WIDTH-bit coefficient needs at most C_WIDTH+1 CSD digit positions
  localparam int N_DIG = C_WIDTH + 1;
  // Width used for the saturation compare: big enough for both sides
  localparam int SAT_W = (ACC_W > O_WIDTH) ? ACC_W : O_WIDTH;
  localparam logic signed [SAT_W-1:0] SAT_MAX =
    {{(SAT_W-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;

  // CSD digit (-1, 0, +1) of 'value' at bit position 'pos'. Scanning from the
  // LSB, an odd remainder ending in ...01 emits +1 and one ending in ...11
  // emits -1, which guarantees no two adjacent nonzero digits.
  function automatic int csd_digit(input int value, input int pos);
    int x;
    int d;
    x = value;
    d = 0;
    for (int i = 0; i <= pos; i++) begin
      if (x[0])
        d = x[1] ? -1 : 1;
      else
        d = 0;
      x = (x - d) >>> 1;
    end
    return d;
  endfunction

  logic signed [I_WIDTH-1:0]      taps [ORDER];
  logic [ORDER*N_DIG*ACC_W-1:0]   terms;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        scaled;
  logic signed [SAT_W-1:0]        wide;
  logic signed [O_WIDTH-1:0]      sat;
  logic signed [O_WIDTH-1:0]      data_q;
  logic                           valid_q;

  // Delay line: shift in a new sample on every enabled edge, freeze otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < ORDER; k++)
        taps[k] <= '0;
    end else if (bus.i_en) begin
      taps[0] <= bus.i_data;
      for (int k = 1; k < ORDER; k++)
        taps[k] <= taps[k-1];
    end
  end

  // Shift-and-add coefficient network; zero digits leave a constant zero term
  for (genvar k = 0; k < ORDER; k++) begin : g_tap
    localparam logic signed [C_WIDTH-1:0] CK = COEFS[k*C_WIDTH +: C_WIDTH];
    logic signed [ACC_W-1:0] ext;

    assign bus.o_taps[k*I_WIDTH +: I_WIDTH] = taps[k];
    assign ext = ACC_W'(taps[k]);

    for (genvar j = 0; j < N_DIG; j++) begin : g_dig
      localparam int D = csd_digit(int'(CK), j);
      if (D == 1) begin : g_pos
        assign terms[(k*N_DIG+j)*ACC_W +: ACC_W] = ext <<< j;
      end else if (D == -1) begin : g_neg
        assign terms[(k*N_DIG+j)*ACC_W +: ACC_W] = -(ext <<< j);
      end else begin : g_zero
        assign terms[(k*N_DIG+j)*ACC_W +: ACC_W] = '0;
      end
    end
  end

  // Sum every partial product into the full-width accumulator
  always_comb begin
    acc = '0;
    for (int i = 0; i < ORDER*N_DIG; i++)
      acc = acc + $signed(terms[i*ACC_W +: ACC_W]);
  end

  // Scale toward minus infinity and clamp into the signed output range
  always_comb begin
    scaled = acc >>> N_SHIFT;
    wide   = SAT_W'(scaled);
    sat    = wide[O_WIDTH-1:0];
    if (wide > SAT_MAX)
      sat = SAT_MAX[O_WIDTH-1:0];
    else if (wide < SAT_MIN)
      sat = SAT_MIN[O_WIDTH-1:0];
  end

  // Output register advances with the delay line; valid echoes the enable
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.i_en;
      if (bus.i_en)
        data_q <= sat;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_fir_csd_varcoef_filter.sv
// Directed bench for the CSD FIR filter. Instance A uses the default low-pass
// set; instance B uses a short set with negative coefficients and no scaling
// so that both saturation limits are reachable.
module tb_fir_csd_varcoef_filter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fir_csd_varcoef_filter_if #(.I_WIDTH(16), .O_WIDTH(24), .ORDER(17)) bus_a ();
  fir_csd_varcoef_filter_if #(.I_WIDTH(16), .O_WIDTH(24), .ORDER(4))  bus_b ();

  fir_csd_varcoef_filter dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a.slave)
  );

  // B coefficients: tap0=-3, tap1=100, tap2=-511, tap3=-512
  fir_csd_varcoef_filter #(
    .I_WIDTH (16),
    .O_WIDTH (24),
    .ORDER   (4),
    .C_WIDTH (10),
    .N_SHIFT (0),
    .COEFS   ({10'h200, 10'h201, 10'd100, 10'h3FD})
  ) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b.slave)
  );

  int imp_a [17] = '{2, 6, 12, 20, 30, 41, 51, 58, 72, 58, 51, 41, 30, 20, 12, 6, 2};
  int imp_b [5]  = '{-300, 10000, -51100, -51200, 0};
  int neg_b [5]  = '{0, -98301, 3178399, -8388608, -8388608};
  int pos_b [5]  = '{0, 98304, -3178496, 8388607, 8388607};

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sum of the first m default coefficients, capped at the full set
  function automatic longint psum(input int m);
    longint s;
    s = 0;
    for (int i = 0; i < m && i < 17; i++)
      s += imp_a[i];
    return s;
  endfunction

  task automatic applyStimulus(input logic en, input logic signed [15:0] da,
                               input logic signed [15:0] db);
    bus_a.i_en   = en;
    bus_a.i_data = da;
    bus_b.i_en   = en;
    bus_b.i_data = db;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic resetPulse(input string tag);
    #2;
    rst = 1'b1;
    #1;
    checkOutput({tag, "_data"}, $signed(bus_a.o_data), 0);
    checkOutput({tag, "_valid"}, {63'b0, bus_a.o_valid}, 0);
    checkOutput({tag, "_taps"}, (bus_a.o_taps == '0) ? 1 : 0, 1);
    rst = 1'b0;
  endtask

  initial begin
    longint held;
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus_a.i_en   = 1'b0;
    bus_a.i_data = '0;
    bus_b.i_en   = 1'b0;
    bus_b.i_data = '0;

    @(negedge clk);
    checkOutput("rst0_data", $signed(bus_a.o_data), 0);
    checkOutput("rst0_valid", {63'b0, bus_a.o_valid}, 0);
    rst = 1'b0;

    $display("[TB] impulse on A");
    applyStimulus(1'b1, 16'sd512, 16'sd0);
    checkOutput("imp_e1_data", $signed(bus_a.o_data), 0);
    checkOutput("imp_e1_valid", {63'b0, bus_a.o_valid}, 1);
    checkOutput("imp_e1_tap0", $signed(bus_a.o_taps[15:0]), 512);
    for (int n = 0; n < 17; n++) begin
      applyStimulus(1'b1, 16'sd0, 16'sd0);
      checkOutput($sformatf("imp%0d", n), $signed(bus_a.o_data), imp_a[n]);
      if (n == 15)
        checkOutput("imp_tap16", $signed(bus_a.o_taps[16*16 +: 16]), 512);
    end
    applyStimulus(1'b1, 16'sd0, 16'sd0);
    checkOutput("imp_tail", $signed(bus_a.o_data), 0);

    $display("[TB] step 1000 on A with enable gap");
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(1'b1, 16'sd1000, 16'sd0);
      checkOutput($sformatf("step%0d", n), $signed(bus_a.o_data),
                  (longint'(1000) * psum(n - 1)) >>> 9);
      if (n == 9)
        checkOutput("step_resume_valid", {63'b0, bus_a.o_valid}, 1);
      if (n == 8) begin
        held = (longint'(1000) * psum(7)) >>> 9;
        for (int g = 0; g < 5; g++) begin
          applyStimulus(1'b0, 16'sd1000, 16'sd0);
          checkOutput($sformatf("gap%0d_valid", g), {63'b0, bus_a.o_valid}, 0);
          checkOutput($sformatf("gap%0d_data", g), $signed(bus_a.o_data), held);
          checkOutput($sformatf("gap%0d_tap7", g), $signed(bus_a.o_taps[7*16 +: 16]), 1000);
          checkOutput($sformatf("gap%0d_tap8", g), $signed(bus_a.o_taps[8*16 +: 16]), 0);
        end
      end
    end

    resetPulse("rst_mid");

    $display("[TB] negative full-scale step on A");
    for (int n = 1; n <= 19; n++) begin
      applyStimulus(1'b1, -16'sd32768, 16'sd0);
      checkOutput($sformatf("neg%0d", n), $signed(bus_a.o_data),
                  (longint'(-32768) * psum(n - 1)) >>> 9);
    end
    checkOutput("neg_final", $signed(bus_a.o_data), -32768);

    resetPulse("rst_small");

    $display("[TB] unit input on A");
    for (int n = 1; n <= 19; n++) begin
      applyStimulus(1'b1, 16'sd1, 16'sd0);
      checkOutput($sformatf("one%0d", n), $signed(bus_a.o_data), psum(n - 1) >>> 9);
    end

    resetPulse("rst_b1");

    $display("[TB] impulse on B (negative coefficients)");
    applyStimulus(1'b1, 16'sd0, 16'sd100);
    checkOutput("b_imp_tap0", $signed(bus_b.o_taps[15:0]), 100);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 16'sd0, 16'sd0);
      checkOutput($sformatf("b_imp%0d", n), $signed(bus_b.o_data), imp_b[n]);
    end

    resetPulse("rst_b2");

    $display("[TB] negative saturation on B");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 16'sd0, 16'sd32767);
      checkOutput($sformatf("b_satn%0d", n), $signed(bus_b.o_data), neg_b[n]);
    end

    resetPulse("rst_b3");

    $display("[TB] positive saturation on B");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 16'sd0, -16'sd32768);
      checkOutput($sformatf("b_satp%0d", n), $signed(bus_b.o_data), pos_b[n]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
